// File: rtl/rgb2hsv_pipe.sv
// rgb2hsv_pipe: fully pipelined RGB -> HSV converter.
// The pipeline has these stages:
//   stage 1 classifies the sextant and orders the channels;
//   stage 2 forms the hue and saturation dividends;
//   DATA_W restoring-divider stages each produce one quotient bit, MSB first;
//   a final register assembles H/S/V, or passes raw RGB in bypass mode.
// Latency is DATA_W+3 ce-qualified clocks. While ce is low every stage holds,
// and the sideband and mode bit hold with them.
module rgb2hsv_pipe #(
    parameter int DATA_W  = 8,
    parameter int HUE_SEG = 42
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              hsv_en,
    input  logic [DATA_W-1:0] R,
    input  logic [DATA_W-1:0] G,
    input  logic [DATA_W-1:0] B,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_de,
    output logic [DATA_W-1:0] H,
    output logic [DATA_W-1:0] S,
    output logic [DATA_W-1:0] V,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_de
);
    localparam int DW = 2 * DATA_W;
    localparam logic [DATA_W-1:0] HSEG = DATA_W'(HUE_SEG);
    localparam logic [DATA_W-1:0] MAXV = '1;

    // Per-pixel context that travels unchanged alongside the dividers.
    typedef struct packed {
        logic [2:0]        sext;
        logic [DATA_W-1:0] vmax;
        logic [DATA_W-1:0] r;
        logic [DATA_W-1:0] g;
        logic [DATA_W-1:0] b;
        logic              en;
        logic              hs;
        logic              vs;
        logic              de;
        logic              zh;   // delta == 0: hue is forced to 0
        logic              zs;   // max == 0: saturation is forced to 0
    } side_t;

    // One restoring step: does the divisor, shifted into place, fit the remainder?
    function automatic logic div_bit(input logic [DW-1:0] rem, input logic [DATA_W-1:0] dvs,
                                     input int sh);
        return rem >= (DW'(dvs) << sh);
    endfunction

    function automatic logic [DW-1:0] div_rem(input logic [DW-1:0] rem,
                                              input logic [DATA_W-1:0] dvs, input int sh);
        logic [DW-1:0] trial;
        trial = DW'(dvs) << sh;
        return (rem >= trial) ? rem - trial : rem;
    endfunction

    // Stage 1 signals
    logic [2:0]        sext_d;
    logic [DATA_W-1:0] max_d, mid_d, min_d;
    side_t             s1_side_q;
    logic [DATA_W-1:0] s1_mid_q, s1_min_q;

    // Stage 2 and divider signals (index 0 = stage 2, index k+1 = divider step k)
    logic [DATA_W-1:0] delta, num;
    logic [DW-1:0]     hrem_d [0:DATA_W-1];
    logic [DW-1:0]     hrem_q [0:DATA_W-1];
    logic [DW-1:0]     srem_d [0:DATA_W-1];
    logic [DW-1:0]     srem_q [0:DATA_W-1];
    logic [DATA_W-1:0] hdiv_d [0:DATA_W-1];
    logic [DATA_W-1:0] hdiv_q [0:DATA_W-1];
    logic [DATA_W-1:0] sdiv_d [0:DATA_W-1];
    logic [DATA_W-1:0] sdiv_q [0:DATA_W-1];
    logic [DATA_W-1:0] hq_d   [0:DATA_W];
    logic [DATA_W-1:0] hq_q   [0:DATA_W];
    logic [DATA_W-1:0] sq_d   [0:DATA_W];
    logic [DATA_W-1:0] sq_q   [0:DATA_W];
    side_t             side_d [0:DATA_W];
    side_t             side_q [0:DATA_W];

    // Final stage signals
    side_t             fin;
    logic [DATA_W-1:0] h_d, s_d, v_d;

    // Sextant classification; the tests are checked in order, so ties resolve top-down.
    always_comb begin
        sext_d = 3'd0;
        max_d  = R;
        mid_d  = G;
        min_d  = B;
        if (R >= G && G >= B) begin
            sext_d = 3'd0; max_d = R; mid_d = G; min_d = B;
        end else if (G > R && R >= B) begin
            sext_d = 3'd1; max_d = G; mid_d = R; min_d = B;
        end else if (G >= B && B > R) begin
            sext_d = 3'd2; max_d = G; mid_d = B; min_d = R;
        end else if (B > G && G > R) begin
            sext_d = 3'd3; max_d = B; mid_d = G; min_d = R;
        end else if (B > R && R >= G) begin
            sext_d = 3'd4; max_d = B; mid_d = R; min_d = G;
        end else begin
            sext_d = 3'd5; max_d = R; mid_d = B; min_d = G;
        end
    end

    // Stage 1 register: ordered channels, sextant, raw pixel and sideband.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_side_q <= '0;
            s1_mid_q  <= '0;
            s1_min_q  <= '0;
        end else if (ce) begin
            s1_side_q <= '{sext: sext_d, vmax: max_d, r: R, g: G, b: B, en: hsv_en,
                           hs: in_hsync, vs: in_vsync, de: in_de, zh: 1'b0, zs: 1'b0};
            s1_mid_q  <= mid_d;
            s1_min_q  <= min_d;
        end
    end

    // Dividend formation followed by one quotient bit per divider step.
    // Even sextants rise from min to mid; odd sextants fall from max to mid.
    always_comb begin
        delta = s1_side_q.vmax - s1_min_q;
        num   = s1_side_q.sext[0] ? (s1_side_q.vmax - s1_mid_q) : (s1_mid_q - s1_min_q);
        hrem_d[0] = DW'(num) * DW'(HSEG);
        srem_d[0] = DW'(delta) * DW'(MAXV);
        hdiv_d[0] = delta;
        sdiv_d[0] = s1_side_q.vmax;
        hq_d[0]   = '0;
        sq_d[0]   = '0;
        side_d[0]    = s1_side_q;
        side_d[0].zh = (delta == '0);
        side_d[0].zs = (s1_side_q.vmax == '0);
        for (int k = 0; k < DATA_W; k++) begin
            hq_d[k+1]   = (hq_q[k] << 1) | DATA_W'(div_bit(hrem_q[k], hdiv_q[k], DATA_W-1-k));
            sq_d[k+1]   = (sq_q[k] << 1) | DATA_W'(div_bit(srem_q[k], sdiv_q[k], DATA_W-1-k));
            side_d[k+1] = side_q[k];
        end
        for (int k = 0; k < DATA_W-1; k++) begin
            hrem_d[k+1] = div_rem(hrem_q[k], hdiv_q[k], DATA_W-1-k);
            srem_d[k+1] = div_rem(srem_q[k], sdiv_q[k], DATA_W-1-k);
            hdiv_d[k+1] = hdiv_q[k];
            sdiv_d[k+1] = sdiv_q[k];
        end
    end

    // Stage 2 and divider pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DATA_W; k++) begin
                hrem_q[k] <= '0;
                srem_q[k] <= '0;
                hdiv_q[k] <= '0;
                sdiv_q[k] <= '0;
            end
            for (int k = 0; k <= DATA_W; k++) begin
                hq_q[k]   <= '0;
                sq_q[k]   <= '0;
                side_q[k] <= '0;
            end
        end else if (ce) begin
            for (int k = 0; k < DATA_W; k++) begin
                hrem_q[k] <= hrem_d[k];
                srem_q[k] <= srem_d[k];
                hdiv_q[k] <= hdiv_d[k];
                sdiv_q[k] <= sdiv_d[k];
            end
            for (int k = 0; k <= DATA_W; k++) begin
                hq_q[k]   <= hq_d[k];
                sq_q[k]   <= sq_d[k];
                side_q[k] <= side_d[k];
            end
        end
    end

    // Result assembly: zero flags mask the divide-by-zero quotients; bypass passes RGB.
    always_comb begin
        fin = side_q[DATA_W];
        h_d = fin.zh ? '0 : DATA_W'(fin.sext) * HSEG + hq_q[DATA_W];
        s_d = fin.zs ? '0 : sq_q[DATA_W];
        v_d = fin.vmax;
        if (!fin.en) begin
            h_d = fin.r;
            s_d = fin.g;
            v_d = fin.b;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            H         <= '0;
            S         <= '0;
            V         <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_de    <= 1'b0;
        end else if (ce) begin
            H         <= h_d;
            S         <= s_d;
            V         <= v_d;
            out_hsync <= fin.hs;
            out_vsync <= fin.vs;
            out_de    <= fin.de;
        end
    end
endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Testbench for rgb2hsv_pipe: a delay-line reference built from the HSV formulas,
// compared against the DUT outputs and sideband every clock.
module tb_rgb2hsv_pipe;
    localparam int W    = 8;
    localparam int HS   = 42;
    localparam int L    = W + 3;
    localparam int MAXV = (1 << W) - 1;
    localparam int EW   = 3 * W + 3;

    // ---------------- clock / reset / signals ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ce = 1'b0;
    logic         hsv_en = 1'b0;
    logic [W-1:0] R = '0, G = '0, B = '0;
    logic         in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
    logic [W-1:0] H, S, V;
    logic         out_hsync, out_vsync, out_de;

    logic [EW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            chk_on = 1'b0;
    int            ties[6] = '{0, 1, 127, 128, 254, 255};

    always #5 clk = ~clk;

    rgb2hsv_pipe #(.DATA_W(W), .HUE_SEG(HS)) dut (
        .clk(clk), .rst(rst), .ce(ce), .hsv_en(hsv_en),
        .R(R), .G(G), .B(B),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .H(H), .S(S), .V(V),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de)
    );

    // ---------------- reference model ----------------
    function automatic logic [3*W-1:0] ref_hsv(input int r, input int g, input int b);
        int mx, mn, delta, sext, n, h, s;
        mx = (r > g) ? r : g;
        mx = (b > mx) ? b : mx;
        mn = (r < g) ? r : g;
        mn = (b < mn) ? b : mn;
        if (r >= g && g >= b)      begin sext = 0; n = g - b; end
        else if (g > r && r >= b)  begin sext = 1; n = g - r; end
        else if (g >= b && b > r)  begin sext = 2; n = b - r; end
        else if (b > g && g > r)   begin sext = 3; n = b - g; end
        else if (b > r && r >= g)  begin sext = 4; n = r - g; end
        else                       begin sext = 5; n = r - b; end
        delta = mx - mn;
        h = (delta == 0) ? 0 : sext * HS + (HS * n) / delta;
        s = (mx == 0) ? 0 : (MAXV * delta) / mx;
        return {W'(h), W'(s), W'(mx)};
    endfunction

    function automatic logic [EW-1:0] ref_out(input logic hs, input logic vs, input logic de,
                                              input logic en, input logic [W-1:0] r,
                                              input logic [W-1:0] g, input logic [W-1:0] b);
        if (en) return {hs, vs, de, ref_hsv(int'(r), int'(g), int'(b))};
        return {hs, vs, de, r, g, b};
    endfunction

    // Delay line of L ce-qualified clocks; reset refills it with zeros.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < L; i++) exp_q.push_back('0);
        end else if (ce) begin
            exp_q.push_front(ref_out(in_hsync, in_vsync, in_de, hsv_en, R, G, B));
            void'(exp_q.pop_back());
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(posedge clk) begin
        logic [EW-1:0] got, want;
        #1;
        if (chk_on) begin
            got  = {out_hsync, out_vsync, out_de, H, S, V};
            want = exp_q[$];
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL hsv_out t=%0t got hs/vs/de=%b%b%b hsv=%0d,%0d,%0d exp hs/vs/de=%b%b%b hsv=%0d,%0d,%0d",
                         $time, got[EW-1], got[EW-2], got[EW-3], got[3*W-1 -: W], got[2*W-1 -: W],
                         got[W-1:0], want[EW-1], want[EW-2], want[EW-3], want[3*W-1 -: W],
                         want[2*W-1 -: W], want[W-1:0]);
            end
        end
    end

    // Hand-computed values that pin the model itself.
    task automatic check_lit(input string name, input int r, input int g, input int b,
                             input int eh, input int es, input int ev);
        logic [3*W-1:0] got, want;
        got  = ref_hsv(r, g, b);
        want = {W'(eh), W'(es), W'(ev)};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input int r, input int g, input int b, input logic en, input logic c);
        @(negedge clk);
        R        = W'(r);
        G        = W'(g);
        B        = W'(b);
        hsv_en   = en;
        ce       = c;
        in_hsync = 1'($urandom_range(0, 1));
        in_vsync = 1'($urandom_range(0, 1));
        in_de    = 1'($urandom_range(0, 1));
    endtask

    function automatic int pick();
        if ($urandom_range(0, 3) == 0) return ties[$urandom_range(0, 5)];
        return int'($urandom_range(0, MAXV));
    endfunction

    // ---------------- stimulus ----------------
    int dir[8][3] = '{'{255, 0, 0}, '{0, 255, 0}, '{0, 0, 255}, '{200, 100, 50},
                      '{50, 100, 200}, '{255, 255, 0}, '{0, 0, 0}, '{128, 128, 128}};

    initial begin
        #1;
        rst    = 1'b1;
        chk_on = 1'b1;

        check_lit("ref_red",   255, 0, 0,       0, 255, 255);
        check_lit("ref_green", 0, 255, 0,      84, 255, 255);
        check_lit("ref_blue",  0, 0, 255,     168, 255, 255);
        check_lit("ref_warm",  200, 100, 50,   14, 191, 200);
        check_lit("ref_cool",  50, 100, 200,  154, 191, 200);
        check_lit("ref_yel",   255, 255, 0,    42, 255, 255);
        check_lit("ref_black", 0, 0, 0,         0, 0, 0);
        check_lit("ref_grey",  128, 128, 128,   0, 0, 128);

        // Reset held with random ce: reset wins.
        repeat (4) drive(pick(), pick(), pick(), 1'b1, 1'($urandom_range(0, 1)));
        @(negedge clk) rst = 1'b0;

        // Some pixels in flight, then a reset pulse that must discard them.
        repeat (5) drive(pick(), pick(), pick(), 1'b1, 1'b1);
        rst = 1'b1;
        repeat (2) drive(pick(), pick(), pick(), 1'b1, 1'b1);
        @(negedge clk) rst = 1'b0;

        // Directed pixels, ce held high.
        for (int i = 0; i < 8; i++) drive(dir[i][0], dir[i][1], dir[i][2], 1'b1, 1'b1);
        repeat (L + 1) drive(0, 0, 0, 1'b1, 1'b1);

        // Ramp with ~50% ce stalls; junk on the inputs while stalled.
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) drive(pick(), pick(), pick(), 1'($urandom_range(0, 1)), 1'b0);
            drive(i & MAXV, (2 * i) & MAXV, MAXV - (i & MAXV), 1'b1, 1'b1);
        end

        // Alternating convert / bypass on consecutive pixels.
        for (int i = 0; i < 64; i++) drive(pick(), pick(), pick(), (i % 2) == 0, 1'b1);

        // Random sweep with occasional stalls and bypass pixels.
        for (int i = 0; i < 3000; i++)
            drive(pick(), pick(), pick(), $urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0);

        repeat (L + 2) drive(0, 0, 0, 1'b1, 1'b1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rgb2hsv_pipe.md
Name: rgb2hsv_pipe

Overview:
Parametrised, fully pipelined RGB-to-HSV converter. It accepts one pixel per enabled clock and produces exact integer HSV with a fixed, documented latency. It replaces the IP-core divider/multiplier chain with internal restoring dividers. It adds async reset, a pixel-accurate clock-enable stall, and a per-pixel bypass mode. It sits in the video path between the RGB source and downstream HSV thresholding, and carries hsync/vsync/de alongside the pixel.

Parameters:
DATA_W, 8, bits per channel in and out; MAXV = 2^DATA_W - 1.
HUE_SEG, 42, hue units per 60-degree sextant; 6*HUE_SEG must be <= MAXV + 1; full circle spans 0..6*HUE_SEG-1.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
ce  in  1  pipeline advance enable; when low, all stages hold.
hsv_en  in  1  per-pixel mode; 1 = convert, 0 = pass R,G,B to H,S,V unchanged.
R, G, B  in  DATA_W each  input pixel, unsigned.
in_hsync, in_vsync, in_de  in  1 each  sync sideband.
H, S, V  out  DATA_W each  result (or bypassed R,G,B).
out_hsync, out_vsync, out_de  out  1 each  sideband aligned with H/S/V.

Behaviour:
- Reset: rst high clears every pipeline register asynchronously; H=S=V=0, all out_* = 0 while rst is high and until the first valid pixel emerges. In-flight pixels are discarded; there is no partial output after reset release.
- Latency: L = DATA_W + 3 ce-qualified clocks (11 for DATA_W=8). Stall with ce low freezes all stages, sideband and hsv_en included; outputs hold their last value. Throughput is 1 pixel per ce cycle.
- Stage 1 (register inputs): classify the sextant. The case list is exhaustive and disjoint; ties resolve as listed.
  - s0: R>=G>=B
  - s1: G>R>=B
  - s2: G>=B>R
  - s3: B>G>R
  - s4: B>R>=G
  - s5: R>=B>G
- Stage 1 also registers max, min and mid.
- Stage 2: compute the following.
  - delta = max - min.
  - Hue numerator n, by sextant: s0 G-B; s1 G-R; s2 B-R; s3 B-G; s4 R-G; s5 R-B.
  - Hue dividend = HUE_SEG*n.
  - S dividend = MAXV*delta.
  - Both dividends are unsigned, 2*DATA_W bits wide.
- Stages 3..DATA_W+2: two parallel restoring dividers, one quotient bit per stage, MSB first. Each produces a DATA_W-bit quotient (guaranteed to fit, since each quotient <= MAXV).
  - Hue divider: divisor = delta.
  - S divider: divisor = max.
  - Sextant index, V = max, hsv_en, bypass RGB and sideband ride along the same stages.
- Final stage (registered):
  - V = max.
  - S = floor(MAXV*delta/max); S = 0 when max = 0.
  - H = sextant*HUE_SEG + floor(HUE_SEG*n/delta); H = 0 when delta = 0 (grey, including black).
  - H is always < 6*HUE_SEG; there is no wrap or negative handling.
- Divide-by-zero: the divider must not produce X/garbage. The zero-divisor flag is carried down the pipe and forces the result to 0.
- Bypass: when hsv_en=0 at input, H/S/V = R/G/B of the same pixel after exactly L cycles. Mode may change on any pixel without bubbles.
- Sideband: out_* = in_* delayed exactly L ce cycles, so out_de marks the same pixel as H/S/V.
- ce low while rst high: reset wins.

Test Plan:
- rst pulse mid-stream, then pixels (255,0,0), (0,255,0), (0,0,255) with ce=1, hsv_en=1 -> after 11 cycles: (H,S,V) = (0,255,255), (84,255,255), (168,255,255); outputs stay 0 until then.
- (200,100,50) -> (14,191,200); (50,100,200) -> (154,191,200); (255,255,0) -> (42,255,255).
- Greys: (0,0,0) -> (0,0,0); (128,128,128) -> (0,0,128); no X on outputs.
- Ramp stream with ce pseudo-random (about 50%) -> output sequence identical to the ce=1 run, and out_de/hsync/vsync aligned with each pixel.
- Alternate hsv_en 1/0 per pixel -> bypass pixels emerge as raw RGB in order, with the same latency and no bubbles.
- Exhaustive 8-bit random sweep vs. reference model of the formulas above -> zero mismatches; repeat with DATA_W=10, HUE_SEG=170.
